// File: rtl/alarm_pkg.sv
// Shared alarm definitions: FSM state encoding, CPU register addresses and
// wall-clock limits used by the alarm unit and CPU-side address decode.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } alarm_state_e;

    localparam logic [3:0] ADDR_AHOUR = 4'hA;
    localparam logic [3:0] ADDR_AMIN  = 4'hB;
    localparam logic [3:0] ADDR_ACTRL = 4'hC;

    localparam logic [5:0] HOUR_MAX = 6'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;

endpackage

// File: rtl/time_add_min.sv
// Combinational hh:mm + ADD_MIN minutes with minute carry into the hour and
// the hour wrapping 23 -> 0. ADD_MIN must be 0..59 and the input time valid.
module time_add_min
    import alarm_pkg::*;
#(
    parameter int unsigned ADD_MIN = 5
) (
    input  logic [5:0] i_hour,
    input  logic [5:0] i_minute,
    output logic [5:0] o_hour,
    output logic [5:0] o_minute
);

    localparam logic [6:0] ADD_C = 7'(ADD_MIN);

    logic [6:0] w_min_sum;
    logic [6:0] w_min_wrap;
    logic [5:0] w_hour_inc;

    // minute sum with at most one carry, then hour wrap at midnight
    always_comb begin
        w_min_sum  = {1'b0, i_minute} + ADD_C;
        w_min_wrap = w_min_sum - 7'd60;
        w_hour_inc = i_hour;
        if (w_min_sum > {1'b0, MIN_MAX}) begin
            o_minute   = w_min_wrap[5:0];
            w_hour_inc = i_hour + 6'd1;
        end else begin
            o_minute   = w_min_sum[5:0];
        end
        if (w_hour_inc > HOUR_MAX) begin
            o_hour = 6'd0;
        end else begin
            o_hour = w_hour_inc;
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm unit: CPU-programmable alarm time and enable, minute-tick matching
// against the timer, and an IDLE/RING/SNOOZE controller with ring timeout.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 10000000,
    parameter int unsigned RING_SECONDS = 60,
    parameter int unsigned SNOOZE_MIN   = 5,
    parameter logic [3:0]  ADDR_AHOUR   = alarm_pkg::ADDR_AHOUR,
    parameter logic [3:0]  ADDR_AMIN    = alarm_pkg::ADDR_AMIN,
    parameter logic [3:0]  ADDR_ACTRL   = alarm_pkg::ADDR_ACTRL
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        w_en_n,
    input  logic [7:0]  t,
    input  logic [15:0] addr,
    input  logic [5:0]  hour,
    input  logic [5:0]  minute,
    input  logic        stop,
    input  logic        snooze,
    output logic        ring,
    output logic [5:0]  alarm_hour,
    output logic [5:0]  alarm_minute,
    output logic        enabled,
    output logic [1:0]  state
);

    localparam logic [31:0] RING_LOAD = 32'(CLK_FREQ * RING_SECONDS - 1);

    logic         r_w_prev;
    logic         r_tick_ok;
    logic [5:0]   r_prev_minute;
    logic [5:0]   r_alarm_hour;
    logic [5:0]   r_alarm_minute;
    logic         r_enabled;
    logic         r_ring;
    alarm_state_e r_state;
    logic [31:0]  r_cnt;
    logic [5:0]   r_snz_hour;
    logic [5:0]   r_snz_minute;

    logic         w_wr;
    logic         w_tick;
    logic         w_match;
    logic         w_snz_hit;
    logic [5:0]   w_tgt_hour;
    logic [5:0]   w_tgt_minute;
    alarm_state_e w_state_nxt;
    logic [31:0]  w_cnt_nxt;
    logic [5:0]   w_snz_hour_nxt;
    logic [5:0]   w_snz_minute_nxt;

    // The first cycle out of reset is masked so a stale prev_minute cannot tick.
    assign w_wr      = ~r_w_prev & w_en_n;
    assign w_tick    = r_tick_ok & (minute != r_prev_minute);
    assign w_match   = w_tick & r_enabled & (hour == r_alarm_hour) & (minute == r_alarm_minute);
    assign w_snz_hit = w_tick & (hour == r_snz_hour) & (minute == r_snz_minute);

    time_add_min #(
        .ADD_MIN  (SNOOZE_MIN)
    ) u_snooze_add (
        .i_hour   (hour),
        .i_minute (minute),
        .o_hour   (w_tgt_hour),
        .o_minute (w_tgt_minute)
    );

    // CPU write strobe, minute history and alarm/enable registers
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_w_prev       <= 1'b1;
            r_tick_ok      <= 1'b0;
            r_prev_minute  <= 6'd0;
            r_alarm_hour   <= 6'd0;
            r_alarm_minute <= 6'd0;
            r_enabled      <= 1'b0;
        end else begin
            r_w_prev      <= w_en_n;
            r_tick_ok     <= 1'b1;
            r_prev_minute <= minute;
            if (w_wr) begin
                case (addr[3:0])
                    ADDR_AHOUR: begin
                        if (t <= {2'b00, HOUR_MAX}) begin
                            r_alarm_hour <= t[5:0];
                        end
                    end
                    ADDR_AMIN: begin
                        if (t <= {2'b00, MIN_MAX}) begin
                            r_alarm_minute <= t[5:0];
                        end
                    end
                    ADDR_ACTRL: r_enabled <= t[0];
                    default: ;
                endcase
            end
        end
    end

    // next-state, ring counter and snooze target
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_snz_hour_nxt   = r_snz_hour;
        w_snz_minute_nxt = r_snz_minute;
        case (r_state)
            ST_IDLE: begin
                if (w_match) begin
                    w_state_nxt = ST_RING;
                    w_cnt_nxt   = RING_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RING: begin
                if (!r_enabled || stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (snooze) begin
                    w_state_nxt      = ST_SNOOZE;
                    w_snz_hour_nxt   = w_tgt_hour;
                    w_snz_minute_nxt = w_tgt_minute;
                end else if (r_cnt == 32'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 32'd1;
                end
            end
            ST_SNOOZE: begin
                if (!r_enabled || stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_snz_hit) begin
                    w_state_nxt = ST_RING;
                    w_cnt_nxt   = RING_LOAD;
                end else begin
                    w_state_nxt = ST_SNOOZE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state, counter, snooze target and registered ring output
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 32'd0;
            r_snz_hour   <= 6'd0;
            r_snz_minute <= 6'd0;
            r_ring       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_snz_hour   <= w_snz_hour_nxt;
            r_snz_minute <= w_snz_minute_nxt;
            r_ring       <= (w_state_nxt == ST_RING);
        end
    end

    assign ring         = r_ring;
    assign alarm_hour   = r_alarm_hour;
    assign alarm_minute = r_alarm_minute;
    assign enabled      = r_enabled;
    assign state        = r_state;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl with a short ring timeout
// (CLK_FREQ=10, RING_SECONDS=2 -> 20 ring cycles) and 5-minute snooze.
module tb_alarm_ctrl;

    logic        clock;
    logic        rst_n;
    logic        w_en_n;
    logic [7:0]  t;
    logic [15:0] addr;
    logic [5:0]  hour;
    logic [5:0]  minute;
    logic        stop;
    logic        snooze;
    logic        ring;
    logic [5:0]  alarm_hour;
    logic [5:0]  alarm_minute;
    logic        enabled;
    logic [1:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    alarm_ctrl #(
        .CLK_FREQ     (10),
        .RING_SECONDS (2),
        .SNOOZE_MIN   (5)
    ) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .w_en_n       (w_en_n),
        .t            (t),
        .addr         (addr),
        .hour         (hour),
        .minute       (minute),
        .stop         (stop),
        .snooze       (snooze),
        .ring         (ring),
        .alarm_hour   (alarm_hour),
        .alarm_minute (alarm_minute),
        .enabled      (enabled),
        .state        (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        addr   = a;
        t      = d;
        w_en_n = 1'b0;
        step(1);
        w_en_n = 1'b1;
        step(1);
    endtask

    task automatic set_time(input logic [5:0] h, input logic [5:0] m);
        hour   = h;
        minute = m;
    endtask

    // drive the timer from (h, m-1) to (h, m) and wait for the ring edge
    task automatic ring_at(input logic [5:0] h, input logic [5:0] m);
        set_time(h, m - 6'd1);
        step(2);
        set_time(h, m);
        step(1);
    endtask

    initial begin
        int ring_cnt;
        rst_n  = 1'b0;
        w_en_n = 1'b1;
        t      = 8'd0;
        addr   = 16'd0;
        hour   = 6'd0;
        minute = 6'd0;
        stop   = 1'b0;
        snooze = 1'b0;
        step(3);
        chk("rst_ring", {31'd0, ring}, 32'd0);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_enabled", {31'd0, enabled}, 32'd0);
        chk("rst_ahour", {26'd0, alarm_hour}, 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        step(2);

        // register write range checks
        cpu_write(16'h000A, 8'd5);
        cpu_write(16'h000B, 8'd10);
        chk("ahour_5", {26'd0, alarm_hour}, 32'd5);
        chk("amin_10", {26'd0, alarm_minute}, 32'd10);
        cpu_write(16'h000A, 8'd24);
        cpu_write(16'h000B, 8'd60);
        chk("ahour_24_ign", {26'd0, alarm_hour}, 32'd5);
        chk("amin_60_ign", {26'd0, alarm_minute}, 32'd10);
        cpu_write(16'h000D, 8'd3);
        chk("bad_addr_ign", {26'd0, alarm_hour}, 32'd5);
        cpu_write(16'h12AA, 8'd23);
        chk("ahour_23_hi_addr", {26'd0, alarm_hour}, 32'd23);
        cpu_write(16'h000B, 8'd59);
        chk("amin_59", {26'd0, alarm_minute}, 32'd59);
        cpu_write(16'h000C, 8'd1);
        chk("en_1", {31'd0, enabled}, 32'd1);
        cpu_write(16'h000C, 8'hFE);
        chk("en_fe", {31'd0, enabled}, 32'd0);

        // basic ring and 20-cycle timeout
        cpu_write(16'h000A, 8'd7);
        cpu_write(16'h000B, 8'd30);
        cpu_write(16'h000C, 8'd1);
        set_time(6'd7, 6'd29);
        step(1);
        chk("pre_match_ring", {31'd0, ring}, 32'd0);
        ring_at(6'd7, 6'd30);
        chk("t1_ring_on", {31'd0, ring}, 32'd1);
        chk("t1_state_ring", {30'd0, state}, 32'd1);
        step(19);
        chk("t1_ring_last", {31'd0, ring}, 32'd1);
        step(1);
        chk("t1_ring_off", {31'd0, ring}, 32'd0);
        chk("t1_state_idle", {30'd0, state}, 32'd0);

        // stop, then no re-ring while time holds
        ring_at(6'd7, 6'd30);
        chk("t2_ring_on", {31'd0, ring}, 32'd1);
        step(3);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("t2_stop_ring", {31'd0, ring}, 32'd0);
        chk("t2_stop_state", {30'd0, state}, 32'd0);
        ring_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (ring) ring_cnt++;
        end
        chk("t2_no_rering", ring_cnt, 32'd0);

        // snooze across midnight: 23:58 + 5 -> 00:03
        cpu_write(16'h000A, 8'd23);
        cpu_write(16'h000B, 8'd58);
        ring_at(6'd23, 6'd58);
        chk("t3_ring_on", {31'd0, ring}, 32'd1);
        step(2);
        snooze = 1'b1;
        step(1);
        snooze = 1'b0;
        chk("t3_snz_state", {30'd0, state}, 32'd2);
        chk("t3_snz_ring", {31'd0, ring}, 32'd0);
        snooze = 1'b1;
        step(1);
        snooze = 1'b0;
        chk("t3_snz_again", {30'd0, state}, 32'd2);
        set_time(6'd0, 6'd2);
        step(2);
        chk("t3_0002_ring", {31'd0, ring}, 32'd0);
        chk("t3_0002_state", {30'd0, state}, 32'd2);
        set_time(6'd0, 6'd3);
        step(1);
        chk("t3_0003_ring", {31'd0, ring}, 32'd1);
        chk("t3_0003_state", {30'd0, state}, 32'd1);
        cpu_write(16'h000B, 8'd0);
        chk("t3_amin_wr_state", {30'd0, state}, 32'd1);
        chk("t3_amin_wr_val", {26'd0, alarm_minute}, 32'd0);
        cpu_write(16'h000B, 8'd58);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("t3_stop_state", {30'd0, state}, 32'd0);

        // stop wins over simultaneous snooze
        ring_at(6'd23, 6'd58);
        chk("t5_ring_on", {31'd0, ring}, 32'd1);
        stop   = 1'b1;
        snooze = 1'b1;
        step(1);
        stop   = 1'b0;
        snooze = 1'b0;
        chk("t5_stop_snz_state", {30'd0, state}, 32'd0);
        chk("t5_stop_snz_ring", {31'd0, ring}, 32'd0);

        // disable during snooze cancels the pending ring
        ring_at(6'd23, 6'd58);
        cpu_write(16'h000C, 8'd1);
        chk("t5_reen_state", {30'd0, state}, 32'd1);
        snooze = 1'b1;
        step(1);
        snooze = 1'b0;
        chk("t5_snz_state", {30'd0, state}, 32'd2);
        cpu_write(16'h000C, 8'd0);
        chk("t5_dis_en", {31'd0, enabled}, 32'd0);
        step(1);
        chk("t5_dis_state", {30'd0, state}, 32'd0);
        set_time(6'd0, 6'd3);
        step(3);
        chk("t5_tgt_ring", {31'd0, ring}, 32'd0);
        chk("t5_tgt_state", {30'd0, state}, 32'd0);

        // asynchronous reset mid-ring
        cpu_write(16'h000C, 8'd1);
        ring_at(6'd23, 6'd58);
        chk("t6_ring_on", {31'd0, ring}, 32'd1);
        step(3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ring", {31'd0, ring}, 32'd0);
        chk("t6_rst_state", {30'd0, state}, 32'd0);
        chk("t6_rst_en", {31'd0, enabled}, 32'd0);
        chk("t6_rst_amin", {26'd0, alarm_minute}, 32'd0);
        set_time(6'd0, 6'd0);
        step(2);
        @(negedge clock);
        rst_n = 1'b1;
        step(5);
        chk("t6_post_ring", {31'd0, ring}, 32'd0);
        chk("t6_post_state", {30'd0, state}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
